alu_issue_ctrl: RTL and testbench

- Sequencing front end for the 32-bit combinational ALU (3-bit ALU_control; flags overflow/carry/negative/zero).
- Accepts one decoded RV32I instruction with operand values over a valid/ready handshake.
- Derives ALU_control, selects operand B (rs2 or immediate) and drives the ALU from registers.
- Captures the result and flags, resolves conditional branches, and presents the registered outcome downstream over a second valid/ready handshake.

---
 rtl/alu_issue_ctrl_if.sv | 46 ++++
 rtl/alu_issue_ctrl.sv | 145 ++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in / ALU / result-out bundle for alu_issue_ctrl.
// The slave modport is the issue controller's view; master is the environment's.
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [6:0]        in_opcode;
  logic [2:0]        in_funct3;
  logic              in_funct7_5;
  logic [DATA_W-1:0] in_rs1_val;
  logic [DATA_W-1:0] in_rs2_val;
  logic [DATA_W-1:0] in_imm;

  logic [CTRL_W-1:0] alu_control;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_overflow;
  logic              alu_negative;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_branch_taken;
  logic              out_illegal;

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_val, in_rs2_val, in_imm,
    output in_ready,
    output alu_control, alu_a, alu_b,
    input  alu_result, alu_overflow, alu_negative,
    output out_valid, out_result, out_branch_taken, out_illegal,
    input  out_ready
  );

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7_5, in_rs1_val, in_rs2_val, in_imm,
    input  in_ready,
    input  alu_control, alu_a, alu_b,
    output alu_result, alu_overflow, alu_negative,
    input  out_valid, out_result, out_branch_taken, out_illegal,
    output out_ready
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational RV32I ALU: decode, drive ALU from registers,
// capture result/flags, resolve branches, hand the outcome downstream.
module alu_issue_ctrl #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_issue_ctrl_if.slave bus
);
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;

  localparam logic [CTRL_W-1:0] C_ADD = CTRL_W'(3'b000);
  localparam logic [CTRL_W-1:0] C_SUB = CTRL_W'(3'b001);
  localparam logic [CTRL_W-1:0] C_AND = CTRL_W'(3'b010);
  localparam logic [CTRL_W-1:0] C_OR  = CTRL_W'(3'b011);
  localparam logic [CTRL_W-1:0] C_SLT = CTRL_W'(3'b101);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;
  typedef enum logic [1:0] {BR_EQ, BR_NE, BR_LT, BR_GE} br_kind_t;

  state_t state_q, state_d;
  logic   accept, capture;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_use_imm, dec_branch, dec_illegal;
  br_kind_t          dec_kind;

  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic              branch_q, illegal_q, taken_q, out_ill_q;
  br_kind_t          kind_q;
  logic              br_cond;

  always_comb begin
    dec_ctrl    = C_ADD;
    dec_use_imm = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    dec_kind    = BR_EQ;
    case (bus.in_opcode)
      OP_R, OP_I: begin
        dec_use_imm = (bus.in_opcode == OP_I);
        case (bus.in_funct3)
          3'b000:  dec_ctrl = (bus.in_opcode == OP_R && bus.in_funct7_5) ? C_SUB : C_ADD;
          3'b010:  dec_ctrl = C_SLT;
          3'b110:  dec_ctrl = C_OR;
          3'b111:  dec_ctrl = C_AND;
          default: dec_illegal = 1'b1;
        endcase
      end
      OP_LOAD, OP_STORE: dec_use_imm = 1'b1;
      OP_BR: begin
        dec_ctrl   = C_SUB;
        dec_branch = 1'b1;
        case (bus.in_funct3)
          3'b000:  dec_kind = BR_EQ;
          3'b001:  dec_kind = BR_NE;
          3'b100:  dec_kind = BR_LT;
          3'b101:  dec_kind = BR_GE;
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    // illegal encodings collapse to a harmless add with no branch semantics
    if (dec_illegal) begin
      dec_ctrl   = C_ADD;
      dec_branch = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        accept  = 1'b1;
        state_d = EXEC;
      end
      EXEC: begin
        capture = 1'b1;
        state_d = DONE;
      end
      DONE: if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // signed compare via the sub flags: a<b exactly when negative^overflow
  always_comb begin
    br_cond = 1'b0;
    case (kind_q)
      BR_EQ: br_cond = (bus.alu_result == '0);
      BR_NE: br_cond = (bus.alu_result != '0);
      BR_LT: br_cond = bus.alu_negative ^ bus.alu_overflow;
      BR_GE: br_cond = ~(bus.alu_negative ^ bus.alu_overflow);
      default: br_cond = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      branch_q  <= 1'b0;
      kind_q    <= BR_EQ;
      illegal_q <= 1'b0;
      result_q  <= '0;
      taken_q   <= 1'b0;
      out_ill_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        ctrl_q    <= dec_ctrl;
        a_q       <= bus.in_rs1_val;
        b_q       <= dec_use_imm ? bus.in_imm : bus.in_rs2_val;
        branch_q  <= dec_branch;
        kind_q    <= dec_kind;
        illegal_q <= dec_illegal;
      end
      if (capture) begin
        result_q  <= illegal_q ? '0 : bus.alu_result;
        taken_q   <= branch_q & br_cond;
        out_ill_q <= illegal_q;
      end
    end
  end

  assign bus.in_ready         = (state_q == IDLE);
  assign bus.out_valid        = (state_q == DONE);
  assign bus.alu_control      = ctrl_q;
  assign bus.alu_a            = a_q;
  assign bus.alu_b            = b_q;
  assign bus.out_result       = result_q;
  assign bus.out_branch_taken = taken_q;
  assign bus.out_illegal      = out_ill_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: behavioural ALU, instruction-level outcome model with a
// per-cycle compare, plus directed vectors carrying hand-computed literals.
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_issue_ctrl_if #(.DATA_W(32), .CTRL_W(3)) bus ();
  alu_issue_ctrl #(.DATA_W(32), .CTRL_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ALU: {overflow, negative, result}
  function automatic logic [33:0] alu_fn(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (c)
      3'b000: begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b001: begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
      3'b010: r = a & b;
      3'b011: r = a | b;
      3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: r = '0;
    endcase
    return {v, r[31], r};
  endfunction

  assign {bus.alu_overflow, bus.alu_negative, bus.alu_result} =
         alu_fn(bus.alu_control, bus.alu_a, bus.alu_b);

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] b;
    logic [31:0] res;
    logic        taken;
    logic        ill;
  } exp_t;

  // Instruction-level meaning, straight from the ISA: signed compares, wrap-around sums.
  function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                 input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    exp_t e;
    logic [31:0] ob;
    e = '0;
    case (op)
      7'b0110011, 7'b0010011: begin
        ob = (op == 7'b0110011) ? rs2 : imm;
        e.b = ob;
        case (f3)
          3'b000: if (op == 7'b0110011 && f7) begin e.ctrl = 3'b001; e.res = rs1 - ob; end
                  else begin e.ctrl = 3'b000; e.res = rs1 + ob; end
          3'b010: begin e.ctrl = 3'b101; e.res = ($signed(rs1) < $signed(ob)) ? 32'd1 : 32'd0; end
          3'b110: begin e.ctrl = 3'b011; e.res = rs1 | ob; end
          3'b111: begin e.ctrl = 3'b010; e.res = rs1 & ob; end
          default: e.ill = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011: begin e.ctrl = 3'b000; e.b = imm; e.res = rs1 + imm; end
      7'b1100011: begin
        e.ctrl = 3'b001; e.b = rs2; e.res = rs1 - rs2;
        case (f3)
          3'b000: e.taken = (rs1 == rs2);
          3'b001: e.taken = (rs1 != rs2);
          3'b100: e.taken = ($signed(rs1) < $signed(rs2));
          3'b101: e.taken = ($signed(rs1) >= $signed(rs2));
          default: e.ill = 1'b1;
        endcase
      end
      default: e.ill = 1'b1;
    endcase
    if (e.ill) begin e.ctrl = 3'b000; e.res = '0; e.taken = 1'b0; end
    return e;
  endfunction

  // Timeline model: an accepted instruction is pending; its result shows two cycles later
  // and retires on the out_ready handshake.
  logic        pending = 1'b0;
  int          cyc = 0;
  int          acc = 0;
  exp_t        m_exp = '0;
  logic [2:0]  m_ctrl = '0;
  logic [31:0] m_a = '0, m_b = '0;
  logic        m_bchk = 1'b1;
  logic        ev;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      m_ctrl  <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_bchk  <= 1'b1;
    end else begin
      if (pending && cyc >= acc + 2 && bus.out_ready)
        pending <= 1'b0;
      else if (!pending && bus.in_valid) begin
        pending <= 1'b1;
        acc     <= cyc;
        m_exp   <= model(bus.in_opcode, bus.in_funct3, bus.in_funct7_5,
                         bus.in_rs1_val, bus.in_rs2_val, bus.in_imm);
        m_ctrl  <= model(bus.in_opcode, bus.in_funct3, bus.in_funct7_5,
                         bus.in_rs1_val, bus.in_rs2_val, bus.in_imm).ctrl;
        m_a     <= bus.in_rs1_val;
        m_b     <= model(bus.in_opcode, bus.in_funct3, bus.in_funct7_5,
                         bus.in_rs1_val, bus.in_rs2_val, bus.in_imm).b;
        m_bchk  <= !model(bus.in_opcode, bus.in_funct3, bus.in_funct7_5,
                          bus.in_rs1_val, bus.in_rs2_val, bus.in_imm).ill;
      end
      cyc <= cyc + 1;
    end
  end

  always @(negedge clk) begin
    ev = pending && (cyc >= acc + 2);
    chk("m_in_ready", 32'(bus.in_ready), 32'(!pending));
    chk("m_out_valid", 32'(bus.out_valid), 32'(ev));
    chk("m_alu_control", 32'(bus.alu_control), 32'(m_ctrl));
    chk("m_alu_a", bus.alu_a, m_a);
    if (m_bchk) chk("m_alu_b", bus.alu_b, m_b);
    if (ev) begin
      chk("m_out_result", bus.out_result, m_exp.res);
      chk("m_out_taken", 32'(bus.out_branch_taken), 32'(m_exp.taken));
      chk("m_out_illegal", 32'(bus.out_illegal), 32'(m_exp.ill));
    end
  end

  task automatic run(input string nm, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                     input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                     input logic [2:0] ec, input logic [31:0] eb, input logic [31:0] er,
                     input logic et, input logic ei, input int bp);
    int n;
    @(posedge clk); #1;
    bus.in_opcode = op; bus.in_funct3 = f3; bus.in_funct7_5 = f7;
    bus.in_rs1_val = rs1; bus.in_rs2_val = rs2; bus.in_imm = imm;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk({nm, "_exec_valid"}, 32'(bus.out_valid), 32'd0);
    chk({nm, "_exec_ready"}, 32'(bus.in_ready), 32'd0);
    chk({nm, "_ctrl"}, 32'(bus.alu_control), 32'(ec));
    chk({nm, "_alu_a"}, bus.alu_a, rs1);
    if (!ei) chk({nm, "_alu_b"}, bus.alu_b, eb);
    n = 0;
    while (!bus.out_valid && n < 8) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 32'(n), 32'd1);
    chk({nm, "_result"}, bus.out_result, er);
    chk({nm, "_taken"}, 32'(bus.out_branch_taken), 32'(et));
    chk({nm, "_illegal"}, 32'(bus.out_illegal), 32'(ei));
    repeat (bp) begin
      @(posedge clk); #1;
      chk({nm, "_bp_valid"}, 32'(bus.out_valid), 32'd1);
      chk({nm, "_bp_result"}, bus.out_result, er);
      chk({nm, "_bp_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk({nm, "_ret_ready"}, 32'(bus.in_ready), 32'd1);
    chk({nm, "_ret_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, LD = 7'b0000011,
                         ST = 7'b0100011, BR = 7'b1100011, LUI = 7'b0110111;

  initial begin
    exp_t e;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.in_opcode = '0; bus.in_funct3 = '0; bus.in_funct7_5 = 1'b0;
    bus.in_rs1_val = '0; bus.in_rs2_val = '0; bus.in_imm = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_alu_control", 32'(bus.alu_control), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_b", bus.alu_b, 32'd0);
    chk("rst_out_result", bus.out_result, 32'd0);
    chk("rst_taken", 32'(bus.out_branch_taken), 32'd0);
    chk("rst_illegal", 32'(bus.out_illegal), 32'd0);
    rst_n = 1'b1;

    // pin the model with hand-worked cases
    e = model(R, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0);
    chk("pin_sub", e.res, 32'hFFFF_FFFE);
    e = model(BR, 3'b100, 1'b0, 32'h8000_0000, 32'd1, 32'd0);
    chk("pin_blt", 32'(e.taken), 32'd1);
    e = model(LUI, 3'b000, 1'b0, 32'd9, 32'd9, 32'd9);
    chk("pin_ill", {31'd0, e.ill}, 32'd1);

    //   name     op  f3      f7    rs1            rs2            imm            ctrl    b              result         t     i     bp
    run("sub",   R,  3'b000, 1'b1, 32'd5,         32'd7,         32'd0,         3'b001, 32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0, 0);
    run("add",   R,  3'b000, 1'b0, 32'd10,        32'd20,        32'd0,         3'b000, 32'd20,        32'd30,        1'b0, 1'b0, 0);
    run("ori",   I,  3'b110, 1'b0, 32'h0F0,       32'h123,       32'h00F,       3'b011, 32'h00F,       32'h0FF,       1'b0, 1'b0, 0);
    run("addi",  I,  3'b000, 1'b1, 32'h64,        32'd5,         32'hFFFF_FFFF, 3'b000, 32'hFFFF_FFFF, 32'h63,        1'b0, 1'b0, 0);
    run("slt",   R,  3'b010, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd0,         3'b101, 32'd1,         32'd1,         1'b0, 1'b0, 0);
    run("andi",  I,  3'b111, 1'b0, 32'hF0F0,      32'd0,         32'h00FF,      3'b010, 32'h00FF,      32'h00F0,      1'b0, 1'b0, 0);
    run("load",  LD, 3'b010, 1'b0, 32'h1000,      32'h55,        32'd8,         3'b000, 32'd8,         32'h1008,      1'b0, 1'b0, 0);
    run("store", ST, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'h77,        32'd1,         3'b000, 32'd1,         32'd0,         1'b0, 1'b0, 0);
    run("blt",   BR, 3'b100, 1'b0, 32'h8000_0000, 32'd1,         32'd0,         3'b001, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0, 0);
    run("beq",   BR, 3'b000, 1'b0, 32'h1234,      32'h1234,      32'd0,         3'b001, 32'h1234,      32'd0,         1'b1, 1'b0, 0);
    run("bne",   BR, 3'b001, 1'b0, 32'h1234,      32'h1234,      32'd0,         3'b001, 32'h1234,      32'd0,         1'b0, 1'b0, 0);
    run("bge_o", BR, 3'b101, 1'b0, 32'd5,         32'h8000_0000, 32'd0,         3'b001, 32'h8000_0000, 32'h8000_0005, 1'b1, 1'b0, 0);
    run("bge_n", BR, 3'b101, 1'b0, 32'd1,         32'd2,         32'd0,         3'b001, 32'd2,         32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    run("lui",   LUI,3'b000, 1'b0, 32'h44,        32'h33,        32'h22,        3'b000, 32'd0,         32'd0,         1'b0, 1'b1, 0);
    run("br010", BR, 3'b010, 1'b0, 32'h3,         32'h3,         32'd0,         3'b000, 32'd0,         32'd0,         1'b0, 1'b1, 0);
    run("sll",   R,  3'b001, 1'b0, 32'h8,         32'h1,         32'd0,         3'b000, 32'd0,         32'd0,         1'b0, 1'b1, 0);
    run("bp",    I,  3'b110, 1'b0, 32'h0F0,       32'd0,         32'h00F,       3'b011, 32'h00F,       32'h0FF,       1'b0, 1'b0, 5);

    // reset while the instruction is in EXEC
    @(posedge clk); #1;
    bus.in_opcode = R; bus.in_funct3 = 3'b000; bus.in_funct7_5 = 1'b1;
    bus.in_rs1_val = 32'hABCD; bus.in_rs2_val = 32'h1111; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("rx_pre_ctrl", 32'(bus.alu_control), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rx_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rx_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rx_alu_control", 32'(bus.alu_control), 32'd0);
    chk("rx_alu_a", bus.alu_a, 32'd0);
    chk("rx_alu_b", bus.alu_b, 32'd0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("rx_no_stale", 32'(bus.out_valid), 32'd0);
    end
    run("post", R,  3'b110, 1'b0, 32'h0A,        32'h50,        32'd0,         3'b011, 32'h50,        32'h5A,        1'b0, 1'b0, 1);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
